// File: rtl/gshare_pht.sv
// Gshare direction predictor: PC^history indexed PHT of 2-bit counters
// with an in-order in-flight queue so each resolve trains its own counter.
module gshare_pht #(
  parameter int W_PHT = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       EN,
  input  logic                       predict,
  input  logic [W_PHT-1:0]           pc,
  input  logic [W_PHT-1:0]           gbhr,
  output logic                       predict_ready,
  output logic                       pred_valid,
  output logic                       pred_taken,
  input  logic                       resolve,
  input  logic                       br_taken,
  output logic                       mispredict,
  output logic                       resolve_err,
  output logic [$clog2(DEPTH):0]     inflight
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int NE = 2 ** W_PHT;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [1:0]       r_pht   [NE];
  logic [W_PHT-1:0] r_q_idx [DEPTH];
  logic             r_q_pred[DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_cnt;
  logic             r_pv;
  logic             r_pt;
  logic             r_mp;
  logic             r_err;

  logic [W_PHT-1:0] w_idx;
  logic             w_pbit;
  logic             w_pacc;
  logic             w_racc;
  logic             w_rerr;
  logic [W_PHT-1:0] w_hidx;
  logic             w_hpred;
  logic [1:0]       w_hctr;
  logic [1:0]       w_hnext;

  assign w_idx   = pc ^ gbhr;
  assign w_pbit  = r_pht[w_idx][1];
  assign predict_ready = (r_cnt != FULL);
  assign w_pacc  = predict && predict_ready && EN;
  assign w_racc  = resolve && EN && (r_cnt != '0);
  assign w_rerr  = resolve && EN && (r_cnt == '0);
  assign w_hidx  = r_q_idx[r_head];
  assign w_hpred = r_q_pred[r_head];
  assign w_hctr  = r_pht[w_hidx];

  // Saturating train step for the counter at the queue head
  always_comb begin
    w_hnext = w_hctr;
    if (br_taken) begin
      if (w_hctr != 2'b11) w_hnext = w_hctr + 2'b01;
    end else begin
      if (w_hctr != 2'b00) w_hnext = w_hctr - 2'b01;
    end
  end

  // PHT storage: reset to weak-NT, trained on resolve
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) r_pht[i] <= 2'b01;
    end else if (w_racc) begin
      r_pht[w_hidx] <= w_hnext;
    end
  end

  // In-flight queue payload, written at the tail on predict accept
  always_ff @(posedge clk) begin
    if (!rst && w_pacc) begin
      r_q_idx[r_tail]  <= w_idx;
      r_q_pred[r_tail] <= w_pbit;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_pacc) r_tail <= r_tail + PW'(1);
      if (w_racc) r_head <= r_head + PW'(1);
      unique case ({w_pacc, w_racc})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Registered prediction and resolve status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pv  <= 1'b0;
      r_pt  <= 1'b0;
      r_mp  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_pv  <= w_pacc;
      if (w_pacc) r_pt <= w_pbit;
      r_mp  <= w_racc && (br_taken != w_hpred);
      r_err <= w_rerr;
    end
  end

  assign pred_valid  = r_pv;
  assign pred_taken  = r_pt;
  assign mispredict  = r_mp;
  assign resolve_err = r_err;
  assign inflight    = r_cnt;

endmodule

// File: tb/tb_gshare_pht.sv
// Directed scoreboard bench for gshare_pht.
// Stimulus pushes hand-computed expectations; a monitor pops and checks.
module tb_gshare_pht;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       EN = 1'b1;
  logic       predict = 1'b0;
  logic [3:0] pc = '0;
  logic [3:0] gbhr = '0;
  logic       predict_ready;
  logic       pred_valid;
  logic       pred_taken;
  logic       resolve = 1'b0;
  logic       br_taken = 1'b0;
  logic       mispredict;
  logic       resolve_err;
  logic [2:0] inflight;

  typedef struct {
    int   id;
    logic pv;
    logic pt;
    logic cpt;
    logic mp;
    logic er;
    int   n;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int vid = 0;

  always #5 clk = ~clk;

  gshare_pht #(.W_PHT(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .EN(EN),
    .predict(predict), .pc(pc), .gbhr(gbhr),
    .predict_ready(predict_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .resolve(resolve), .br_taken(br_taken),
    .mispredict(mispredict), .resolve_err(resolve_err),
    .inflight(inflight)
  );

  task automatic chk(input string nm, input int id,
                     input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL v%0d %s got=%0d want=%0d", id, nm, got, want);
    end
  endtask

  // Monitor: outputs just after each edge belong to the oldest vector
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pred_valid", e.id, int'(pred_valid), int'(e.pv));
      if (e.cpt) chk("pred_taken", e.id, int'(pred_taken), int'(e.pt));
      chk("mispredict", e.id, int'(mispredict), int'(e.mp));
      chk("resolve_err", e.id, int'(resolve_err), int'(e.er));
      chk("inflight", e.id, int'(inflight), e.n);
      chk("predict_ready", e.id, int'(predict_ready), int'(e.n != 4));
    end
  end

  // One vector per cycle: inputs, then expected outputs after the edge
  task automatic v(input logic r, input logic e, input logic p,
                   input logic [3:0] a, input logic [3:0] g,
                   input logic rs, input logic bt,
                   input logic epv, input logic ept, input logic ecp,
                   input logic emp, input logic eer, input int en);
    exp_t x;
    @(negedge clk);
    rst = r; EN = e; predict = p; pc = a; gbhr = g;
    resolve = rs; br_taken = bt;
    vid++;
    x.id = vid; x.pv = epv; x.pt = ept; x.cpt = ecp;
    x.mp = emp; x.er = eer; x.n = en;
    q.push_back(x);
  endtask

  initial begin
    // reset, and reset overriding requests
    v(1,1,0,4'h0,4'h0,0,0, 0,0,1,0,0, 0);
    v(1,1,1,4'h3,4'h5,1,1, 0,0,1,0,0, 0);
    // training at idx 6 (pc 3 ^ gbhr 5)
    v(0,1,1,4'h3,4'h5,0,0, 1,0,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,1, 0,0,0,1,0, 0);
    v(0,1,1,4'h3,4'h5,0,0, 1,1,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,1, 0,0,0,0,0, 0);
    v(0,1,1,4'h3,4'h5,0,0, 1,1,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,0, 0,0,0,1,0, 0);
    v(0,1,1,4'h3,4'h5,0,0, 1,1,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,0, 0,0,0,1,0, 0);
    v(0,1,1,4'h3,4'h5,0,0, 1,0,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,0, 0,0,0,0,0, 0);
    // resolve on empty queue
    v(0,1,0,4'h0,4'h0,1,0, 0,0,0,0,1, 0);
    v(0,1,0,4'h0,4'h0,0,0, 0,0,0,0,0, 0);
    // saturation at 00 then climb back
    v(0,1,1,4'h3,4'h5,0,0, 1,0,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,0, 0,0,0,0,0, 0);
    v(0,1,1,4'h3,4'h5,0,0, 1,0,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,1, 0,0,0,1,0, 0);
    v(0,1,1,4'h3,4'h5,0,0, 1,0,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,1, 0,0,0,1,0, 0);
    // fill queue: idx 6, 9, 6, 0
    v(0,1,1,4'h3,4'h5,0,0, 1,1,1,0,0, 1);
    v(0,1,1,4'hA,4'h3,0,0, 1,0,1,0,0, 2);
    v(0,1,1,4'h3,4'h5,0,0, 1,1,1,0,0, 3);
    v(0,1,1,4'h5,4'h5,0,0, 1,0,1,0,0, 4);
    // full: predict dropped, even alongside a resolve
    v(0,1,1,4'h3,4'h5,0,0, 0,0,0,0,0, 4);
    v(0,1,1,4'h3,4'h5,1,1, 0,0,0,0,0, 3);
    v(0,1,0,4'h0,4'h0,1,0, 0,0,0,0,0, 2);
    v(0,1,0,4'h0,4'h0,1,1, 0,0,0,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,1, 0,0,0,1,0, 0);
    v(0,1,1,4'h0,4'h0,0,0, 1,1,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,1, 0,0,0,0,0, 0);
    // three in flight at strong-T, then reset
    v(0,1,1,4'h3,4'h5,0,0, 1,1,1,0,0, 1);
    v(0,1,1,4'h3,4'h5,0,0, 1,1,1,0,0, 2);
    v(0,1,1,4'h3,4'h5,0,0, 1,1,1,0,0, 3);
    v(1,1,0,4'h0,4'h0,0,0, 0,0,1,0,0, 0);
    v(0,1,0,4'h0,4'h0,1,1, 0,0,0,0,1, 0);
    // same-cycle predict and resolve at idx 6
    v(0,1,1,4'h3,4'h5,0,0, 1,0,1,0,0, 1);
    v(0,1,1,4'h3,4'h5,1,1, 1,0,1,1,0, 1);
    v(0,1,0,4'h0,4'h0,1,1, 0,0,0,1,0, 0);
    v(0,1,1,4'h3,4'h5,0,0, 1,1,1,0,0, 1);
    // EN low: nothing moves, pred_taken holds
    v(0,0,1,4'h3,4'h5,1,0, 0,1,1,0,0, 1);
    v(0,0,0,4'h0,4'h0,1,0, 0,1,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,0, 0,0,0,1,0, 0);
    v(0,1,1,4'h3,4'h5,0,0, 1,1,1,0,0, 1);
    v(0,1,0,4'h0,4'h0,1,1, 0,0,0,0,0, 0);
    v(0,0,0,4'h0,4'h0,1,0, 0,0,0,0,0, 0);
    v(0,1,0,4'h0,4'h0,0,0, 0,0,0,0,0, 0);
    @(negedge clk);
    predict = 0; resolve = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 0, q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gshare_pht.md
# gshare_pht

Gshare direction predictor core that consumes the global branch history register value alongside the fetch PC. It hashes the two into a pattern history table (PHT) of 2-bit saturating counters and returns a taken/not-taken prediction one cycle later. It holds the index and prediction of every in-flight branch in an in-order queue, so that each resolve updates the exact counter used at predict time and flags mispredicts. It sits between fetch and the history register's resolve path.

## Interface
- W_PHT, 4: PHT index width; PHT holds 2^W_PHT counters; PC slice and history width.
- DEPTH, 4: maximum in-flight (predicted, unresolved) branches; power of 2, ≥2.

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- EN  input  1  global enable; when 0, no state changes and no pulses.
- predict  input  1  predict request for a branch this cycle.
- pc  input  W_PHT  PC index slice of the predicted branch.
- gbhr  input  W_PHT  current global history value.
- predict_ready  output  1  queue not full; a predict is accepted only when high.
- pred_valid  output  1  one-cycle pulse: pred_taken is valid.
- pred_taken  output  1  predicted direction.
- resolve  input  1  oldest in-flight branch resolves this cycle.
- br_taken  input  1  actual direction of the resolving branch.
- mispredict  output  1  one-cycle pulse: the resolved direction differed from its prediction.
- resolve_err  output  1  one-cycle pulse: resolve arrived with the queue empty.
- inflight  output  $clog2(DEPTH)+1  number of queued branches.

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. A counter predicts taken when its MSB is 1.
- Training rule: taken increments, saturating at 11. Not-taken decrements, saturating at 00.
- Index: idx = pc XOR gbhr, computed W_PHT bits wide, no carry.
- Predict accept: predict && predict_ready && EN.
  - On accept, read pht[idx], register MSB into pred_taken and pulse pred_valid.
  - Push {idx, MSB} into the queue tail.
- Resolve accept: resolve && EN && inflight != 0.
  - Pop the queue head.
  - Update pht[head.idx] with br_taken.
  - Register mispredict = (br_taken != head.pred).
- Resolve with an empty queue (resolve && EN && inflight == 0):
  - No PHT or queue change.
  - resolve_err pulses next cycle.
- Predict and resolve in the same cycle are both performed.
  - The predict read sees the pre-update counter value, even when the indices match.
  - inflight is unchanged.
- predict_ready = (inflight != DEPTH). It does not account for a same-cycle resolve, so a full queue rejects predicts even while popping.
- A predict seen while predict_ready is 0 is dropped silently: no pulse, no push.
- Queue is a circular buffer. Head and tail pointers wrap modulo DEPTH. inflight is tracked separately to distinguish full from empty.
- EN = 0: requests are ignored, and pred_valid, mispredict and resolve_err are 0 the next cycle. pred_taken holds its last value.

## Timing
- Reset (rst high at a clock edge):
  - All PHT counters become 01.
  - Queue is flushed: head = tail = 0, inflight = 0.
  - pred_valid, pred_taken, mispredict and resolve_err are 0; predict_ready reads 1.
  - Reset overrides any same-cycle predict or resolve.
- Mid-operation reset discards all in-flight entries; no mispredict is reported for them.
- Predict latency is 1 cycle: pred_valid and pred_taken are registered, asserted in the cycle after accept.
- Resolve latency is 1 cycle: mispredict and resolve_err are registered, and the counter update is visible to predicts accepted in the next cycle.
- inflight and predict_ready reflect all accepts in the cycle following them.
- Full sustained throughput: one predict and one resolve per cycle.

## Test plan
- Reset, then predict pc=4'h3, gbhr=4'h5 → idx=4'h6; next cycle pred_valid=1, pred_taken=0, inflight=1.
- Training at idx 6:
  - Two predict/resolve(br_taken=1) pairs → counter 01→10→11.
  - Third predict → pred_taken=1.
  - Resolve with br_taken=0 → mispredict=1, counter=10.
- Queue full: 4 predicts with no resolve → inflight=4, predict_ready=0.
  - A 5th predict is dropped, with no pred_valid.
  - One resolve → inflight=3, predict_ready=1 next cycle.
- Resolve when inflight=0 → resolve_err=1 for one cycle; all counters unchanged, inflight stays 0.
- Same-cycle predict and resolve(br_taken=1), both at idx 6 with counter 01 → pred_taken=0 (pre-update value), counter becomes 10, inflight unchanged.
- Reset with 3 branches in flight and idx 6 counter at 11 → inflight=0, counter=01; a following resolve gives resolve_err=1.
- EN=0 with predict=1 and resolve=1 held → no pulses, inflight and counters unchanged.
